// File: rtl/capture_writer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | capture_writer_pkg : FSM state encoding and write-data field positions   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package capture_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WAIT_B  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int c_wdata_bits = 32;
  localparam int c_q_lsb      = 0;

  // I sits directly above Q; anything above I is zero.
  function automatic int i_lsb(input int q_bits);
    return c_q_lsb + q_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sample_fifo : register-based input FIFO with synchronous clear           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int                c_ptr_bits = $clog2(DEPTH);
  localparam logic [c_ptr_bits:0] c_ptr_one = (c_ptr_bits+1)'(1);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ptr_bits:0] r_wr_ptr;
  logic [c_ptr_bits:0] r_rd_ptr;
  logic                w_push;
  logic                w_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full   = (r_wr_ptr[c_ptr_bits] != r_rd_ptr[c_ptr_bits]) &&
                  (r_wr_ptr[c_ptr_bits-1:0] == r_rd_ptr[c_ptr_bits-1:0]);
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign head   = r_mem[r_rd_ptr[c_ptr_bits-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_ptr_bits-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/capture_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | capture_writer : buffers I/Q samples and writes one capture downstream   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module capture_writer
  import capture_writer_pkg::*;
#(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12,
  parameter int fifo_depth    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sample_valid,
  input  logic [i_bits-1:0]       i_in,
  input  logic [q_bits-1:0]       q_in,
  output logic [index_bits-1:0]   m_axi_waddr,
  output logic [c_wdata_bits-1:0] m_axi_wdata,
  output logic                    m_axi_wvalid,
  input  logic                    s_axi_wready,
  input  logic                    s_axi_bvalid,
  input  logic                    s_axi_bresp,
  output logic                    m_axi_bready,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    wr_error
);

  localparam int                    c_i_lsb     = i_lsb(q_bits);
  localparam int                    c_cnt_bits  = $clog2(buffer_length + 1);
  localparam logic [c_cnt_bits-1:0] c_buf_len   = c_cnt_bits'(buffer_length);
  localparam logic [c_cnt_bits-1:0] c_cnt_one   = c_cnt_bits'(1);
  localparam logic [index_bits-1:0] c_last_addr = index_bits'(buffer_length - 1);
  localparam logic [index_bits-1:0] c_addr_one  = index_bits'(1);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [index_bits-1:0]     r_addr;
  logic [c_cnt_bits-1:0]     r_accept_cnt;
  logic                      r_overflow;
  logic                      r_wr_error;

  logic [c_wdata_bits-1:0]   w_sample;
  logic [c_wdata_bits-1:0]   w_head;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_start;
  logic                      w_window;
  logic                      w_below;
  logic                      w_push;
  logic                      w_drop;
  logic                      w_pop;
  logic                      w_wvalid;
  logic                      w_bready;
  logic                      w_busy;
  logic                      w_done;

  always_comb begin
    w_sample                   = '0;
    w_sample[c_i_lsb +: i_bits] = i_in;
    w_sample[c_q_lsb +: q_bits] = q_in;
  end

  assign w_start  = (r_state == ST_IDLE) && start;
  assign w_window = (r_state == ST_CAPTURE) || (r_state == ST_WAIT_B);
  assign w_below  = (r_accept_cnt < c_buf_len);
  // Only drops inside the capture quota count as overflow; surplus samples are silently ignored.
  assign w_push   = w_window && sample_valid && !w_full && w_below;
  assign w_drop   = w_window && sample_valid && w_full && w_below;
  assign w_pop    = (r_state == ST_WAIT_B) && s_axi_bvalid;

  sample_fifo #(
    .WIDTH (c_wdata_bits),
    .DEPTH (fifo_depth)
  ) u_sample_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_start),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_sample),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  always_comb begin
    w_next_state = r_state;
    w_wvalid     = 1'b0;
    w_bready     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_busy   = 1'b1;
        w_wvalid = !w_empty;
        if (!w_empty && s_axi_wready) w_next_state = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        w_busy   = 1'b1;
        w_bready = 1'b1;
        if (s_axi_bvalid) begin
          w_next_state = (r_addr == c_last_addr) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_accept_cnt <= '0;
      r_overflow   <= 1'b0;
      r_wr_error   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_addr       <= '0;
        r_accept_cnt <= '0;
        r_overflow   <= 1'b0;
        r_wr_error   <= 1'b0;
      end else begin
        if (w_push) r_accept_cnt <= r_accept_cnt + c_cnt_one;
        if (w_drop) r_overflow <= 1'b1;
        if (w_pop) begin
          // Address saturates on the last slot so it never points past the buffer.
          if (r_addr != c_last_addr) r_addr <= r_addr + c_addr_one;
          if (s_axi_bresp) r_wr_error <= 1'b1;
        end
      end
    end
  end

  assign m_axi_waddr  = r_addr;
  assign m_axi_wdata  = w_wvalid ? w_head : '0;
  assign m_axi_wvalid = w_wvalid;
  assign m_axi_bready = w_bready;
  assign busy         = w_busy;
  assign done         = w_done;
  assign overflow     = r_overflow;
  assign wr_error     = r_wr_error;

endmodule
`default_nettype wire

// File: tb/tb_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_capture_writer : directed scoreboard bench for capture_writer         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_capture_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] i_in = '0;
  logic [11:0] q_in = '0;
  logic [3:0]  m_axi_waddr;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wvalid;
  logic        s_axi_wready;
  logic        s_axi_bvalid = 1'b0;
  logic        s_axi_bresp;
  logic        m_axi_bready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        wr_error;

  bit wready_en  = 1'b0;
  int stall_addr = -1;
  int err_addr   = -1;

  assign s_axi_wready = wready_en && !(stall_addr >= 0 && int'(m_axi_waddr) == stall_addr);
  assign s_axi_bresp  = s_axi_bvalid && err_addr >= 0 && int'(m_axi_waddr) == err_addr;

  capture_writer #(
    .buffer_length (10),
    .index_bits    (4),
    .i_bits        (12),
    .q_bits        (12),
    .fifo_depth    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sample_valid),
    .i_in         (i_in),
    .q_in         (q_in),
    .m_axi_waddr  (m_axi_waddr),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wvalid (m_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bresp  (s_axi_bresp),
    .m_axi_bready (m_axi_bready),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .wr_error     (wr_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors   = 0;
  int   checks   = 0;
  int   writes   = 0;
  int   done_cnt = 0;
  int   exp_addr = 0;

  function automatic logic [31:0] pack_iq(input int i, input int q);
    logic [31:0] w;
    w        = '0;
    w[23:12] = i[11:0];
    w[11:0]  = q[11:0];
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_wvalid"},   m_axi_wvalid, 0);
    check({tag, "_bready"},   m_axi_bready, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_wr_error"}, wr_error, 0);
    check({tag, "_waddr"},    m_axi_waddr, 0);
    check({tag, "_wdata"},    m_axi_wdata, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic send(input int i, input int q, input bit accepted, input bit st);
    exp_t e;
    i_in         = 12'(i);
    q_in         = 12'(q);
    sample_valid = 1'b1;
    start        = st;
    if (accepted) begin
      e.addr = 4'(exp_addr);
      e.data = pack_iq(i, q);
      exp_q.push_back(e);
      exp_addr++;
    end
    tick(1);
    sample_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick(1);
      n++;
    end
    tick(4);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  // Write-channel monitor: every accepted write is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axi_wvalid && s_axi_wready) begin
        writes++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write observed=addr %0d expected=no write", m_axi_waddr);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("waddr", m_axi_waddr, mon_e.addr);
          check("wdata", m_axi_wdata, mon_e.data);
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int w0;
    int n;

    // Reset state
    rst = 1'b1;
    tick(3);
    outputs_zero("reset");
    rst = 1'b0;
    tick(1);
    outputs_zero("post_reset");

    // Normal capture; samples paced at the two-cycle write rate so the FIFO never fills
    wready_en    = 1'b1;
    s_axi_bvalid = 1'b1;
    d0 = done_cnt;
    w0 = writes;
    do_start();
    check("busy_after_start", busy, 1);
    for (int k = 0; k < 10; k++) begin
      send(k, -k, 1'b1, 1'b0);
      tick(1);
    end
    wait_done(d0, 60);
    check("s1_overflow", overflow, 0);
    check("s1_wr_error", wr_error, 0);
    check("s1_writes", writes - w0, 10);
    check("s1_queue_empty", exp_q.size(), 0);
    check("s1_busy", busy, 0);

    // Stalled write channel: back-to-back samples overflow a full FIFO
    wready_en = 1'b0;
    d0 = done_cnt;
    w0 = writes;
    do_start();
    for (int k = 0; k < 10; k++) send(k, -k, k < 4, 1'b0);
    tick(10);
    check("s2_wvalid_held", m_axi_wvalid, 1);
    check("s2_waddr_held", m_axi_waddr, 0);
    check("s2_wdata_held", m_axi_wdata, pack_iq(0, 0));
    check("s2_overflow", overflow, 1);
    wready_en = 1'b1;
    tick(12);
    for (int k = 10; k < 16; k++) begin
      send(k, -k, 1'b1, 1'b0);
      tick(1);
    end
    wait_done(d0, 60);
    check("s2_overflow_sticky", overflow, 1);
    check("s2_writes", writes - w0, 10);
    check("s2_queue_empty", exp_q.size(), 0);

    // Error response on address 3
    err_addr = 3;
    d0 = done_cnt;
    w0 = writes;
    do_start();
    check("s3_overflow_cleared", overflow, 0);
    for (int k = 0; k < 10; k++) begin
      send(k + 20, k - 20, 1'b1, 1'b0);
      tick(1);
    end
    wait_done(d0, 60);
    err_addr = -1;
    check("s3_wr_error", wr_error, 1);
    check("s3_writes", writes - w0, 10);
    check("s3_queue_empty", exp_q.size(), 0);

    // Reset while a write at address 5 is pending
    stall_addr = 5;
    do_start();
    check("s4_wr_error_cleared", wr_error, 0);
    for (int k = 0; k < 10; k++) begin
      send(k, k, 1'b1, 1'b0);
      tick(1);
    end
    n = 0;
    while (!(m_axi_wvalid && m_axi_waddr == 4'd5) && n < 50) begin
      tick(1);
      n++;
    end
    check("s4_pending_wvalid", m_axi_wvalid, 1);
    check("s4_pending_waddr", m_axi_waddr, 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    outputs_zero("mid_write_reset");
    exp_q.delete();
    stall_addr = -1;
    tick(2);

    // Restart from address 0; first word checks the I/Q packing directly
    d0 = done_cnt;
    w0 = writes;
    do_start();
    send(-1, 1, 1'b1, 1'b0);
    check("s6_wvalid", m_axi_wvalid, 1);
    check("s6_waddr", m_axi_waddr, 0);
    check("s6_wdata_pack", m_axi_wdata, 32'h00FFF001);
    tick(1);
    for (int k = 1; k < 10; k++) begin
      send(k, -k, 1'b1, 1'b0);
      tick(1);
    end
    wait_done(d0, 60);
    check("s4_writes", writes - w0, 10);
    check("s4_overflow", overflow, 0);
    check("s4_queue_empty", exp_q.size(), 0);

    // start pulses while busy and surplus samples are ignored
    d0 = done_cnt;
    w0 = writes;
    do_start();
    for (int k = 0; k < 15; k++) begin
      send(k + 40, -k, k < 10, (k == 3 || k == 7 || k == 9));
      tick(1);
    end
    wait_done(d0, 60);
    tick(10);
    check("s5_single_done", done_cnt - d0, 1);
    check("s5_writes", writes - w0, 10);
    check("s5_overflow", overflow, 0);
    check("s5_idle", busy, 0);
    check("s5_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/capture_writer.md
CAPTURE_WRITER -- requirements
Module: capture_writer

Interface
REQ-001 The block SHALL have parameter buffer_length, default 10, meaning the number of words written per capture.
REQ-002 The block SHALL have parameter index_bits, default 4, meaning the write address width; 2^index_bits >= buffer_length.
REQ-003 The block SHALL have parameters i_bits and q_bits, default 12 each, meaning the sample widths; i_bits+q_bits <= 32.
REQ-004 The block SHALL have parameter fifo_depth, default 4, meaning the input FIFO depth (power of two, >= 2).
REQ-005 The block SHALL have these ports: clk, input, 1, the single clock; all logic samples on its rising edge.
REQ-006 rst, input, 1, synchronous active-high reset.
REQ-007 start, input, 1, arms a capture when idle.
REQ-008 sample_valid, input, 1, i_in and q_in hold a sample this cycle.
REQ-009 i_in, input, i_bits, signed I sample; q_in, input, q_bits, signed Q sample.
REQ-010 m_axi_waddr, output, index_bits, write address.
REQ-011 m_axi_wdata, output, 32, packed sample.
REQ-012 m_axi_wvalid, output, 1, address and data valid.
REQ-013 s_axi_wready, input, 1, downstream write accept.
REQ-014 s_axi_bvalid, input, 1, write response valid; s_axi_bresp, input, 1, 1 = error.
REQ-015 m_axi_bready, output, 1, response accept.
REQ-016 busy, output, 1; done, output, 1 (one-cycle pulse); overflow, output, 1 (sticky); wr_error, output, 1 (sticky).

Function
REQ-017 The FSM SHALL have states IDLE, CAPTURE, WAIT_B, DONE.
REQ-018 In IDLE, start=1 SHALL clear FIFO, address, accept counter, overflow, wr_error and move to CAPTURE next cycle; start outside IDLE SHALL be ignored.
REQ-019 In CAPTURE and WAIT_B, a sample with sample_valid=1 SHALL be pushed if the FIFO is not full and fewer than buffer_length samples have been accepted since start.
REQ-020 A sample offered while the FIFO is full and the accept count is below buffer_length SHALL be dropped and SHALL set overflow; samples beyond buffer_length SHALL be ignored without flagging.
REQ-021 A sample pushed at cycle N SHALL be able to drive m_axi_wvalid at cycle N+1 at the earliest.
REQ-022 In CAPTURE with a non-empty FIFO, m_axi_wvalid SHALL be 1 with m_axi_wdata = FIFO head and m_axi_waddr = current address, all held stable until s_axi_wready=1.
REQ-023 m_axi_wdata[i_bits+q_bits-1:q_bits] SHALL be I, [q_bits-1:0] SHALL be Q, and the upper bits SHALL be zero.
REQ-024 On wvalid&wready the FSM SHALL enter WAIT_B, deassert wvalid, and assert m_axi_bready for the whole of WAIT_B.
REQ-025 In WAIT_B, s_axi_bvalid=1 SHALL pop the FIFO and increment the address; bresp=1 SHALL set wr_error, and the capture SHALL still advance.
REQ-026 If the response completes address buffer_length-1, the FSM SHALL go to DONE, else to CAPTURE.
REQ-027 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE; the address SHALL never exceed buffer_length-1.
REQ-028 busy SHALL be 1 in CAPTURE, WAIT_B and DONE.
REQ-029 Simultaneous push and pop in one cycle SHALL leave the occupancy unchanged.

Reset
REQ-030 rst SHALL override all other inputs, including mid-write with wvalid pending.
REQ-031 On rst, the FSM SHALL go to IDLE, the FIFO SHALL empty, and the address and counter SHALL clear.
REQ-032 On rst, wvalid, bready, busy, done, overflow, wr_error, waddr and wdata SHALL all be 0.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the wdata packing field positions.
REQ-034 The input FIFO SHALL be a sub-module named sample_fifo, with push, pop, full, empty and head.

Verification
REQ-035 Bench SHALL check: start, then 10 continuous samples (I=k, Q=-k), wready and bvalid always 1 -> addresses 0..9 written in order, wdata correct, one done pulse, overflow=0.
REQ-036 Bench SHALL check: wready held low 20 cycles with 10 continuous samples -> overflow=1, first 4 samples written in order, buffer writes still complete.
REQ-037 Bench SHALL check: bresp=1 on address 3 -> wr_error=1, addresses 4..9 still written, done pulses.
REQ-038 Bench SHALL check: rst asserted while wvalid=1 at address 5 -> next cycle all outputs 0 and state IDLE; a new start rewrites from address 0.
REQ-039 Bench SHALL check: start pulsed while busy and 15 samples supplied -> exactly 10 writes, no second capture.
REQ-040 Bench SHALL check: i_bits=12, q_bits=12, I=-1, Q=1 -> wdata=0x00FFF001.
